// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter 2x2 covariance blocks.
package kf_pkg;

  localparam int unsigned KF_N    = 20;
  localparam int unsigned KF_FRAC = 10;
  // Start-to-done latency of prior_cov_semipar.
  localparam int unsigned ENG_LAT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StBusy,
    StDone
  } state_e;

  // Ceiling log2, never less than 1 so index ports stay at least one bit wide.
  function automatic int unsigned clog2_min1(int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // LSB of element idx in a packed {m00,m01,m10,m11} word of n-bit elements.
  function automatic int elem_lsb(int idx, int n);
    return (3 - idx) * n;
  endfunction

endpackage

// File: rtl/kf_rr_pick.sv
// Round-robin pick: first requester after rr_ptr, wrapping modulo NCH.
module kf_rr_pick #(
  parameter int unsigned NCH = 2,
  parameter int unsigned IDW = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] cand [NCH];

  // Candidate order: rr_ptr+1, rr_ptr+2, ... modulo NCH.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cand[k] = IDW'((32'(rr_ptr) + 32'(k) + 32'd1) % NCH);
    end
  end

  // Take the first requesting candidate.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!any && req[cand[k]]) begin
        any           = 1'b1;
        idx           = cand[k];
        gnt[cand[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prior_cov_semipar.sv
// Covariance predict engine: P_prior = A*P*A' + Q on 2x2 signed fixed point.
// T = A*P in the first run cycle, T*A' + Q in the second; done is held back to ENG_LAT.
module prior_cov_semipar
  import kf_pkg::*;
#(
  parameter int unsigned N    = KF_N,
  parameter int unsigned FRAC = KF_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [4*N-1:0] a,
  input  logic [4*N-1:0] p,
  input  logic [4*N-1:0] q,
  output logic           done,
  output logic [4*N-1:0] p_prior
);

  localparam int unsigned CW = clog2_min1(ENG_LAT);
  localparam logic [CW-1:0] CntLast = CW'(ENG_LAT - 1);

  logic [4*N-1:0]        a_q, p_q, q_q;
  logic signed [N-1:0]   t_q [4];
  logic signed [N-1:0]   r_q [4];
  logic signed [N-1:0]   a_e [4], p_e [4], q_e [4], t_n [4], r_n [4];
  logic [CW-1:0]         cnt_q;
  logic                  run_q;

  function automatic logic signed [N-1:0] fmul(logic signed [N-1:0] x, logic signed [N-1:0] y);
    logic signed [2*N-1:0] prod;
    prod = x * y;
    return N'(prod >>> FRAC);
  endfunction

  // Unpack operands and form both matrix products.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_e[i] = a_q[elem_lsb(i, N) +: N];
      p_e[i] = p_q[elem_lsb(i, N) +: N];
      q_e[i] = q_q[elem_lsb(i, N) +: N];
    end
    t_n[0] = fmul(a_e[0], p_e[0]) + fmul(a_e[1], p_e[2]);
    t_n[1] = fmul(a_e[0], p_e[1]) + fmul(a_e[1], p_e[3]);
    t_n[2] = fmul(a_e[2], p_e[0]) + fmul(a_e[3], p_e[2]);
    t_n[3] = fmul(a_e[2], p_e[1]) + fmul(a_e[3], p_e[3]);
    r_n[0] = fmul(t_q[0], a_e[0]) + fmul(t_q[1], a_e[1]) + q_e[0];
    r_n[1] = fmul(t_q[0], a_e[2]) + fmul(t_q[1], a_e[3]) + q_e[1];
    r_n[2] = fmul(t_q[2], a_e[0]) + fmul(t_q[3], a_e[1]) + q_e[2];
    r_n[3] = fmul(t_q[2], a_e[2]) + fmul(t_q[3], a_e[3]) + q_e[3];
  end

  // Operand capture, two compute steps, then count out the fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      p_q   <= '0;
      q_q   <= '0;
      t_q   <= '{default: '0};
      r_q   <= '{default: '0};
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      p_q   <= p;
      q_q   <= q;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(0)) t_q <= t_n;
      if (cnt_q == CW'(1)) r_q <= r_n;
      if (cnt_q == CntLast) run_q <= 1'b0;
    end
  end

  assign done    = run_q && (cnt_q == CntLast);
  assign p_prior = {r_q[0], r_q[1], r_q[2], r_q[3]};

endmodule

// File: rtl/prior_cov_arbiter.sv
// Round-robin sharing of one prior_cov_semipar engine between NCH filter channels.
module prior_cov_arbiter
  import kf_pkg::*;
#(
  parameter int unsigned N       = KF_N,
  parameter int unsigned FRAC    = KF_FRAC,
  parameter int unsigned NCH     = 2,
  parameter int unsigned TIMEOUT = 32,
  localparam int unsigned IDW    = clog2_min1(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*4*N-1:0] a_in,
  input  logic [NCH*4*N-1:0] p_in,
  input  logic [NCH*4*N-1:0] q_in,
  output logic [NCH-1:0]     gnt,
  output logic               busy,
  output logic [NCH-1:0]     done_ch,
  output logic [IDW-1:0]     done_id,
  output logic [4*N-1:0]     p_out,
  output logic               timeout
);

  localparam int unsigned CW = clog2_min1(TIMEOUT);
  localparam logic [CW-1:0] WdLast = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] sel_q, rr_ptr_q;
  logic [4*N-1:0] a_op_q, p_op_q, q_op_q;
  logic [CW-1:0]  wd_cnt_q;
  logic           abort_q;

  logic [NCH-1:0] pick_gnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           eng_start, eng_done;
  logic [4*N-1:0] eng_p;
  logic           busy_ok, busy_abort;

  kf_rr_pick #(
    .NCH(NCH),
    .IDW(IDW)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  prior_cov_semipar #(
    .N   (N),
    .FRAC(FRAC)
  ) u_eng (
    .clk    (clk),
    .rst_n  (~rst),
    .start  (eng_start),
    .a      (a_op_q),
    .p      (p_op_q),
    .q      (q_op_q),
    .done   (eng_done),
    .p_prior(eng_p)
  );

  // A done in the first BUSY cycle (count still 0) may be left over, so it is ignored.
  assign busy_ok    = (wd_cnt_q != '0) && eng_done;
  assign busy_abort = !busy_ok && (wd_cnt_q == WdLast);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE always passes through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pick_any) state_d = StLoad;
      StLoad:  state_d = StStart;
      StStart: state_d = StBusy;
      StBusy:  if (busy_ok || busy_abort) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != StIdle);
    eng_start = (state_q == StStart);
    done_ch   = '0;
    if (state_q == StDone) done_ch[sel_q] = 1'b1;
    timeout   = (state_q == StDone) && abort_q;
  end

  // Grant, operand capture, watchdog and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      sel_q    <= '0;
      rr_ptr_q <= IDW'(NCH - 1);
      a_op_q   <= '0;
      p_op_q   <= '0;
      q_op_q   <= '0;
      wd_cnt_q <= '0;
      abort_q  <= 1'b0;
      done_id  <= '0;
      p_out    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            gnt   <= pick_gnt;
            sel_q <= pick_idx;
          end
        end
        StLoad: begin
          a_op_q <= a_in[32'(sel_q) * (4 * N) +: 4 * N];
          p_op_q <= p_in[32'(sel_q) * (4 * N) +: 4 * N];
          q_op_q <= q_in[32'(sel_q) * (4 * N) +: 4 * N];
        end
        StStart: begin
          wd_cnt_q <= '0;
          abort_q  <= 1'b0;
        end
        StBusy: begin
          // Result, id and pointer land on DONE entry so they line up with done_ch.
          if (busy_ok || busy_abort) begin
            abort_q  <= busy_abort;
            done_id  <= sel_q;
            rr_ptr_q <= sel_q;
            p_out    <= busy_abort ? '0 : eng_p;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        StDone:  gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prior_cov_arbiter.sv
// Scoreboard bench for prior_cov_arbiter: stimulus pushes expected completions, monitor pops them.
module tb_prior_cov_arbiter;

  localparam int N   = 20;
  localparam int NCH = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NCH-1:0]     req = '0;
  logic [NCH*4*N-1:0] a_in, p_in, q_in;
  logic [NCH-1:0]     gnt, done_ch;
  logic               busy, timeout;
  logic [0:0]         done_id;
  logic [4*N-1:0]     p_out;

  prior_cov_arbiter #(
    .N      (20),
    .FRAC   (10),
    .NCH    (2),
    .TIMEOUT(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_in   (a_in),
    .p_in   (p_in),
    .q_in   (q_in),
    .gnt    (gnt),
    .busy   (busy),
    .done_ch(done_ch),
    .done_id(done_id),
    .p_out  (p_out),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [79:0] p;
    logic        to;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [NCH-1:0] mon_oh;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  function automatic logic [79:0] diag(input int d);
    logic [19:0] x;
    x = d[19:0];
    return {x, 20'd0, 20'd0, x};
  endfunction

  task automatic expect_done(input int ch, input logic [79:0] p, input logic to, input int at);
    exp_t e;
    e.ch = ch;
    e.p  = p;
    e.to = to;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the next done_ch pulse; optionally drop the served request.
  task automatic wait_done(input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (done_ch == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_ch == '0) chk("wait_done_timeout", 96'd0, 96'd1);
    else if (drop) req = req & ~done_ch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: one-hot grant every cycle, scoreboard compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", 96'($onehot0(gnt)), 96'd1);
      if (done_ch != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 96'(done_ch), 96'd0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.ch] = 1'b1;
          chk("done_ch", 96'(done_ch), 96'(mon_oh));
          chk("gnt_at_done", 96'(gnt), 96'(mon_oh));
          chk("done_id", 96'(done_id), 96'(mon_e.ch));
          chk("p_out", 96'(p_out), 96'(mon_e.p));
          chk("timeout", 96'(timeout), 96'(mon_e.to));
          chk("done_cycle", 96'(cyc), 96'(mon_e.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c;
    int n;
    // Channel 0: A=I, P=I, Q=0.25I. Channel 1: A=2I, P=I, Q=0.
    a_in = {diag(2048), diag(1024)};
    p_in = {diag(1024), diag(1024)};
    q_in = {diag(0), diag(256)};

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_gnt", 96'(gnt), 96'd0);
    chk("rst_done_ch", 96'(done_ch), 96'd0);
    chk("rst_done_id", 96'(done_id), 96'd0);
    chk("rst_p_out", 96'(p_out), 96'd0);
    chk("rst_timeout", 96'(timeout), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single channel 0 request: 11-cycle latency, diagonal 1280.
    req = 2'b01;
    expect_done(0, diag(1280), 1'b0, cyc + 11);
    wait_done(1'b1);

    // Simultaneous requests after reset: channel 0 first, channel 1 twelve cycles later.
    do_reset();
    req = 2'b11;
    expect_done(0, diag(1280), 1'b0, cyc + 11);
    expect_done(1, diag(4096), 1'b0, cyc + 23);
    wait_done(1'b1);
    wait_done(1'b1);

    // Both held for four services: strict alternation.
    do_reset();
    req = 2'b11;
    c = cyc;
    expect_done(0, diag(1280), 1'b0, c + 11);
    expect_done(1, diag(4096), 1'b0, c + 23);
    expect_done(0, diag(1280), 1'b0, c + 35);
    expect_done(1, diag(4096), 1'b0, c + 47);
    repeat (4) wait_done(1'b0);
    req = 2'b00;

    // Engine done held low: watchdog abort after 32 BUSY cycles.
    @(negedge clk);
    force dut.eng_done = 1'b0;
    req = 2'b01;
    expect_done(0, diag(0), 1'b1, cyc + 35);
    wait_done(1'b1);
    release dut.eng_done;
    @(negedge clk);
    chk("abort_back_idle", 96'(busy), 96'd0);

    // Channel 1 drops req (and its P changes) mid-operation; result still delivered.
    @(negedge clk);
    req = 2'b10;
    c = cyc;
    expect_done(1, diag(4096), 1'b0, c + 11);
    n = 0;
    while (!gnt[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_ch1_seen", 96'(gnt[1]), 96'd1);
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    p_in[159:80] = diag(3000);
    wait_done(1'b1);
    p_in[159:80] = diag(1024);
    @(negedge clk);
    @(negedge clk);
    chk("idle_no_gnt", 96'(gnt), 96'd0);
    chk("idle_not_busy", 96'(busy), 96'd0);

    // Reset during BUSY: everything clears at once, then a fresh request works.
    @(negedge clk);
    req = 2'b01;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 96'(busy), 96'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 96'(busy), 96'd0);
    chk("mid_rst_gnt", 96'(gnt), 96'd0);
    chk("mid_rst_done_ch", 96'(done_ch), 96'd0);
    chk("mid_rst_timeout", 96'(timeout), 96'd0);
    chk("mid_rst_p_out", 96'(p_out), 96'd0);
    chk("mid_rst_done_id", 96'(done_id), 96'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_done(0, diag(1280), 1'b0, cyc + 11);
    wait_done(1'b1);

    @(negedge clk);
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
